// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a single-port memory as circular storage, with an optional post-reset zero scrub.
// Latency: a pop accepted on edge N gives PopValid/PopData during the cycle after edge N.
// Backpressure: PushReady drops when full, flushing, scrubbing or when a pop takes the port this cycle.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  Flush,
    input  logic                  PushValid,
    input  logic [DATA_WIDTH-1:0] PushData,
    output logic                  PushReady,
    input  logic                  PopReq,
    output logic                  PopValid,
    output logic [DATA_WIDTH-1:0] PopData,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Full,
    output logic                  Empty,
    output logic                  MemEnable,
    output logic                  MemReadWrite,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] MemDataIn,
    input  logic [DATA_WIDTH-1:0] MemDataOut
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH:0]   CNT_FULL   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] SCRUB_LAST = {ADDR_WIDTH{1'b1}};
    localparam state_t                RST_STATE  = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] scrub_addr;
    logic [ADDR_WIDTH:0]   count;
    logic                  pop_vld;
    logic                  is_run;
    logic                  pop_ok;
    logic                  push_ok;

    assign is_run    = (state == ST_RUN);
    assign Full      = (count == CNT_FULL);
    assign Empty     = (count == '0);
    assign Count     = count;
    assign PopValid  = pop_vld;
    assign PopData   = MemDataOut;

    // The read wins the single port; a push only proceeds on a cycle with no pop.
    assign pop_ok    = is_run && PopReq && !Empty && !Flush;
    assign PushReady = is_run && !Full && !Flush && !pop_ok;
    assign push_ok   = PushValid && PushReady;

    // Next-state and memory command: scrub writes in INIT, read-or-write in RUN.
    always_comb begin
        state_nxt    = state;
        MemEnable    = 1'b0;
        MemReadWrite = 1'b1;
        MemAddress   = rd_ptr;
        MemDataIn    = PushData;
        case (state)
            ST_INIT: begin
                MemEnable    = 1'b1;
                MemReadWrite = 1'b0;
                MemAddress   = scrub_addr;
                MemDataIn    = '0;
                if (scrub_addr == SCRUB_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pop_ok) begin
                    MemEnable    = 1'b1;
                    MemReadWrite = 1'b1;
                    MemAddress   = rd_ptr;
                end else if (push_ok) begin
                    MemEnable    = 1'b1;
                    MemReadWrite = 1'b0;
                    MemAddress   = wr_ptr;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // State, pointers and occupancy; reset beats everything, flush clears only in RUN.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state      <= RST_STATE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            scrub_addr <= '0;
            count      <= '0;
            pop_vld    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pop_vld <= pop_ok;
            if (!is_run) begin
                scrub_addr <= scrub_addr + PTR_ONE;
            end else if (Flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                count  <= count - CNT_ONE;
            end else if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                count  <= count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural single-port memory attached.
// Inputs change 1 time unit after the rising edge; outputs are compared 1 unit later.
// Table rows cover the steady-state handshake; hand sequences cover scrub, full/wrap and reset.
module tb_ram_fifo_ctrl;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fl;
    logic       pv;
    logic [7:0] pd;
    logic       pr;
    logic       push_rdy;
    logic       pop_vld;
    logic [7:0] pop_dat;
    logic [8:0] cnt;
    logic       full;
    logic       empty;
    logic       mem_en;
    logic       mem_rw;
    logic [7:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    logic [7:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CLEAR_ON_RESET(1)) dut (
        .Clock(clk), .ResetN(rst_n), .Flush(fl),
        .PushValid(pv), .PushData(pd), .PushReady(push_rdy),
        .PopReq(pr), .PopValid(pop_vld), .PopData(pop_dat),
        .Count(cnt), .Full(full), .Empty(empty),
        .MemEnable(mem_en), .MemReadWrite(mem_rw), .MemAddress(mem_addr),
        .MemDataIn(mem_din), .MemDataOut(mem_dout)
    );

    // Single-port memory: write stores DataIn, read registers DataOut and holds it.
    always @(posedge clk) begin
        if (mem_en) begin
            if (!mem_rw) mem[mem_addr] <= mem_din;
            else         mem_dout      <= mem[mem_addr];
        end
    end

    typedef struct {
        logic       pv;
        logic [7:0] pd;
        logic       pr;
        logic       fl;
        logic       rdy;
        logic       en;
        logic       rw;
        logic [7:0] addr;
        int         cnt;
        logic       popv;
        logic [7:0] popd;
    } vec_t;

    vec_t vt [25];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pv = 1'b0; pd = 8'h00; pr = 1'b0; fl = 1'b0;
    endtask

    initial begin
        //            pv  pd     pr fl  rdy en rw addr   cnt popv popd
        vt[0]  = '{H, 8'h55, L, L,  H, H, L, 8'd0,  0, L, 8'h00};
        vt[1]  = '{H, 8'hAA, L, L,  H, H, L, 8'd1,  1, L, 8'h00};
        vt[2]  = '{L, 8'h00, H, L,  L, H, H, 8'd0,  2, L, 8'h00};
        vt[3]  = '{L, 8'h00, H, L,  L, H, H, 8'd1,  1, H, 8'h55};
        vt[4]  = '{L, 8'h00, L, L,  H, L, H, 8'd2,  0, H, 8'hAA};
        vt[5]  = '{L, 8'h00, L, L,  H, L, H, 8'd2,  0, L, 8'h00};
        vt[6]  = '{H, 8'h11, L, L,  H, H, L, 8'd2,  0, L, 8'h00};
        vt[7]  = '{H, 8'h22, L, L,  H, H, L, 8'd3,  1, L, 8'h00};
        vt[8]  = '{H, 8'h33, L, L,  H, H, L, 8'd4,  2, L, 8'h00};
        vt[9]  = '{H, 8'h44, H, L,  L, H, H, 8'd2,  3, L, 8'h00};
        vt[10] = '{H, 8'h44, H, L,  L, H, H, 8'd3,  2, H, 8'h11};
        vt[11] = '{H, 8'h44, H, L,  L, H, H, 8'd4,  1, H, 8'h22};
        vt[12] = '{H, 8'h44, H, L,  H, H, L, 8'd5,  0, H, 8'h33};
        vt[13] = '{L, 8'h00, L, L,  H, L, H, 8'd5,  1, L, 8'h00};
        vt[14] = '{L, 8'h00, H, L,  L, H, H, 8'd5,  1, L, 8'h00};
        vt[15] = '{L, 8'h00, L, L,  H, L, H, 8'd6,  0, H, 8'h44};
        vt[16] = '{H, 8'hA0, L, L,  H, H, L, 8'd6,  0, L, 8'h00};
        vt[17] = '{H, 8'hA1, L, L,  H, H, L, 8'd7,  1, L, 8'h00};
        vt[18] = '{H, 8'hA2, L, L,  H, H, L, 8'd8,  2, L, 8'h00};
        vt[19] = '{H, 8'hA3, L, L,  H, H, L, 8'd9,  3, L, 8'h00};
        vt[20] = '{H, 8'hA4, L, L,  H, H, L, 8'd10, 4, L, 8'h00};
        vt[21] = '{H, 8'h77, H, H,  L, L, H, 8'd6,  5, L, 8'h00};
        vt[22] = '{H, 8'h77, L, L,  H, H, L, 8'd0,  0, L, 8'h00};
        vt[23] = '{L, 8'h00, H, L,  L, H, H, 8'd0,  1, L, 8'h00};
        vt[24] = '{L, 8'h00, L, L,  H, L, H, 8'd1,  0, H, 8'h77};

        // Reset state
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        #1;
        chk("rst.empty", int'(empty), 1);
        chk("rst.full", int'(full), 0);
        chk("rst.count", int'(cnt), 0);
        chk("rst.pop_vld", int'(pop_vld), 0);
        chk("rst.push_rdy", int'(push_rdy), 0);
        rst_n = 1'b1;

        // Scrub: 256 zero writes, pushes/pops/flush ignored meanwhile
        for (int i = 0; i < 256; i++) begin
            pv = 1'b1; pd = 8'hC3; pr = 1'b1; fl = (i == 50);
            #1;
            chk($sformatf("init%0d.addr", i), int'(mem_addr), i);
            chk($sformatf("init%0d.ctl", i),
                int'({mem_en, mem_rw, empty, full, push_rdy, pop_vld, mem_din, cnt}),
                int'({6'b101000, 17'd0}));
            tick();
        end
        idle();
        #1;
        chk("run.push_rdy", int'(push_rdy), 1);
        chk("run.mem_en", int'(mem_en), 0);
        chk("run.count", int'(cnt), 0);

        // Steady-state vectors
        for (int i = 0; i < 25; i++) begin
            pv = vt[i].pv; pd = vt[i].pd; pr = vt[i].pr; fl = vt[i].fl;
            #1;
            chk($sformatf("row%0d.push_rdy", i), int'(push_rdy), int'(vt[i].rdy));
            chk($sformatf("row%0d.mem_en", i), int'(mem_en), int'(vt[i].en));
            chk($sformatf("row%0d.mem_rw", i), int'(mem_rw), int'(vt[i].rw));
            chk($sformatf("row%0d.mem_addr", i), int'(mem_addr), int'(vt[i].addr));
            chk($sformatf("row%0d.mem_din", i), int'(mem_din), int'(vt[i].pd));
            chk($sformatf("row%0d.count", i), int'(cnt), vt[i].cnt);
            chk($sformatf("row%0d.empty", i), int'(empty), (vt[i].cnt == 0) ? 1 : 0);
            chk($sformatf("row%0d.pop_vld", i), int'(pop_vld), int'(vt[i].popv));
            if (vt[i].popv) begin
                chk($sformatf("row%0d.pop_dat", i), int'(pop_dat), int'(vt[i].popd));
            end
            tick();
        end

        // Fill to full, blocked push, pop, wrapped push
        idle();
        fl = 1'b1;
        tick();
        fl = 1'b0;
        for (int i = 0; i < 256; i++) begin
            pv = 1'b1; pd = 8'(i);
            #1;
            chk($sformatf("fill%0d.addr", i), int'(mem_addr), i);
            tick();
        end
        pv = 1'b1; pd = 8'hEE;
        #1;
        chk("full.full", int'(full), 1);
        chk("full.count", int'(cnt), 256);
        chk("full.push_rdy", int'(push_rdy), 0);
        chk("full.mem_en", int'(mem_en), 0);
        tick();
        #1;
        chk("full.count_hold", int'(cnt), 256);
        pr = 1'b1;
        #1;
        chk("full.pop_cmd", int'({mem_en, mem_rw, mem_addr}), int'({2'b11, 8'd0}));
        chk("full.pop_push_rdy", int'(push_rdy), 0);
        tick();
        pr = 1'b0; pv = 1'b1; pd = 8'h99;
        #1;
        chk("wrap.pop_vld", int'(pop_vld), 1);
        chk("wrap.pop_dat", int'(pop_dat), 8'h00);
        chk("wrap.count", int'(cnt), 255);
        chk("wrap.push_rdy", int'(push_rdy), 1);
        chk("wrap.wr_cmd", int'({mem_en, mem_rw, mem_addr, mem_din}), int'({2'b10, 8'd0, 8'h99}));
        tick();
        idle();
        #1;
        chk("wrap.full", int'(full), 1);
        chk("wrap.count_end", int'(cnt), 256);

        // Reset mid-scrub restarts the scrub from address 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        #1;
        chk("scrub.addr100", int'(mem_addr), 100);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("scrub.restart_addr", int'(mem_addr), 0);
        chk("scrub.restart_cmd", int'({mem_en, mem_rw, push_rdy}), int'(3'b100));
        for (int i = 0; i < 256; i++) tick();
        #1;
        chk("scrub.run_rdy", int'(push_rdy), 1);

        // Reset right after an accepted pop drops the following read and clears state
        pv = 1'b1; pd = 8'h5A;
        tick();
        pd = 8'hA5;
        tick();
        pv = 1'b0; pr = 1'b1;
        #1;
        chk("rstpop.pop_cmd", int'({mem_en, mem_rw, mem_addr}), int'({2'b11, 8'd0}));
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstpop.first_vld", int'(pop_vld), 1);
        chk("rstpop.first_dat", int'(pop_dat), 8'h5A);
        tick();
        rst_n = 1'b1; pr = 1'b0;
        #1;
        chk("rstpop.pop_vld", int'(pop_vld), 0);
        chk("rstpop.count", int'(cnt), 0);
        chk("rstpop.empty", int'(empty), 1);
        chk("rstpop.scrub_cmd", int'({mem_en, mem_rw, mem_addr, push_rdy}), int'({2'b10, 8'd0, 1'b0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
